// File: rtl/dac_serial_multi.sv
// Multi-channel serial DAC driver: shifts one word per enabled channel over a shared
// SCLK/SDI bus with per-channel chip selects, then strobes LD_n; also issues CLR_n pulses.
module dac_serial_multi #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LD_CYCLES = 3
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic                     locked,
  input  logic                     start,
  output logic                     ready,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     clr_req,
  output logic                     done,
  output logic [NUM_CH-1:0]        CS_n,
  output logic                     SCLK,
  output logic                     SDI,
  output logic                     LD_n,
  output logic                     CLR_n
);

  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BitW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CntMax = (CLK_DIV > LD_CYCLES) ? CLK_DIV : LD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] LdLast  = CntW'(LD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCsSetup, StShiftLo, StShiftHi, StCsHold, StLdPulse, StClrPulse, StDone
  } state_e;

  state_e                    state_q;
  logic [CntW-1:0]           cnt_q;
  logic [BitW-1:0]           bit_q;
  logic [ChW-1:0]            ch_q;
  logic [NUM_CH-1:0]         mask_q;
  logic [NUM_CH*DATA_W-1:0]  data_q;
  logic                      clr_pend_q;

  logic                      first_found, nxt_found;
  logic [ChW-1:0]            first_ch, nxt_ch;
  logic [DATA_W-1:0]         word;

  assign ready = (state_q == StIdle) & locked & ~clr_pend_q & ~clr_req;

  // Descending scan so the lowest-index enabled channel wins.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = ChW'(i);
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = ChW'(i);
      end
    end
    word = data_q[int'(ch_q)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      clr_pend_q <= 1'b0;
      CS_n       <= '1;
      SCLK       <= 1'b1;
      SDI        <= 1'b0;
      LD_n       <= 1'b1;
      CLR_n      <= 1'b1;
      done       <= 1'b0;
    end else begin
      // A request arriving during a running clear pulse is merged into it.
      if (clr_req && (state_q != StIdle) && (state_q != StClrPulse)) clr_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (locked && (clr_pend_q || clr_req)) begin
            state_q    <= StClrPulse;
            CLR_n      <= 1'b0;
            cnt_q      <= LdLast;
            clr_pend_q <= 1'b0;
          end else if (start && ready) begin
            data_q <= ch_data;
            mask_q <= ch_mask;
            if (first_found) begin
              state_q <= StCsSetup;
              ch_q    <= first_ch;
              CS_n    <= ~(NUM_CH'(1) << first_ch);
              cnt_q   <= DivLast;
            end else begin
              state_q <= StDone;
            end
          end else if (clr_req) begin
            clr_pend_q <= 1'b1;
          end
        end
        StCsSetup: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= StShiftLo;
            SCLK    <= 1'b0;
            SDI     <= word[DATA_W-1];
            bit_q   <= BitW'(DATA_W - 1);
            cnt_q   <= DivLast;
          end
        end
        StShiftLo: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= StShiftHi;
            SCLK    <= 1'b1;
            cnt_q   <= DivLast;
          end
        end
        StShiftHi: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (bit_q == '0) begin
            state_q <= StCsHold;
            CS_n    <= '1;
            SDI     <= 1'b0;
            cnt_q   <= DivLast;
          end else begin
            state_q <= StShiftLo;
            SCLK    <= 1'b0;
            SDI     <= word[bit_q - BitW'(1)];
            bit_q   <= bit_q - BitW'(1);
            cnt_q   <= DivLast;
          end
        end
        StCsHold: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (nxt_found) begin
            state_q <= StCsSetup;
            ch_q    <= nxt_ch;
            CS_n    <= ~(NUM_CH'(1) << nxt_ch);
            cnt_q   <= DivLast;
          end else begin
            state_q <= StLdPulse;
            LD_n    <= 1'b0;
            cnt_q   <= LdLast;
          end
        end
        StLdPulse: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= StDone;
            LD_n    <= 1'b1;
            done    <= 1'b1;
          end
        end
        StClrPulse: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= StIdle;
            CLR_n   <= 1'b1;
          end
        end
        StDone: begin
          // An empty frame enters with done low and raises it one cycle later.
          if (!done) done <= 1'b1;
          else begin
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_multi.sv
// Scoreboard bench for dac_serial_multi: stimulus pushes expected transfers, done times and
// strobe widths; a bus monitor decodes CS_n/SCLK/SDI/LD_n/CLR_n/done and pops to compare.
module tb_dac_serial_multi;
  localparam int DW    = 12;
  localparam int NC    = 2;
  localparam int CD    = 2;
  localparam int LDC   = 3;
  localparam int DWALL = NC * DW;
  localparam int FRAME = CD * (2 * DW + 2);

  logic             clk = 1'b0;
  logic             rst, locked, start, ready, clr_req, done;
  logic             SCLK, SDI, LD_n, CLR_n;
  logic [DWALL-1:0] ch_data;
  logic [NC-1:0]    ch_mask, CS_n;

  dac_serial_multi #(.DATA_W(DW), .NUM_CH(NC), .CLK_DIV(CD), .LD_CYCLES(LDC)) dut (
    .clk_50M(clk), .rst(rst), .locked(locked), .start(start), .ready(ready),
    .ch_data(ch_data), .ch_mask(ch_mask), .clr_req(clr_req), .done(done),
    .CS_n(CS_n), .SCLK(SCLK), .SDI(SDI), .LD_n(LD_n), .CLR_n(CLR_n)
  );

  always #10 clk = ~clk;

  typedef struct {int ch; logic [DW-1:0] word;} xfer_t;
  xfer_t xq[$];
  int    doneq[$];
  int    ldq[$];
  int    clrq[$];  // expected CLR_n fall sample, -1 when only ordering matters

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  logic [NC-1:0] prev_cs = '1;
  logic          prev_sclk = 1'b1, prev_ld = 1'b1, prev_clr = 1'b1;
  logic [DW-1:0] shreg = '0;
  int nbits = 0, cur_ch = 0, ld_cnt = 0, clr_cnt = 0;
  int clr_fall_cyc = -1, clr_rise_cyc = -1, last_done_cyc = -1;
  int sdi_bad = 0, stray = 0, multi_cs = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      prev_cs = '1; prev_sclk = 1'b1; prev_ld = 1'b1; prev_clr = 1'b1;
      nbits = 0; ld_cnt = 0; clr_cnt = 0;
    end else begin
      if (CS_n == '1) begin
        if (SDI) sdi_bad++;
        if (SCLK != prev_sclk) stray++;
      end else begin
        if ($countones(~CS_n) != 1) multi_cs++;
        for (int i = 0; i < NC; i++) if (!CS_n[i]) cur_ch = i;
        if (!prev_sclk && SCLK) begin
          shreg = {shreg[DW-2:0], SDI};
          nbits++;
        end
      end
      if (CS_n == '1 && prev_cs != '1) begin
        check("xfer_expected", xq.size() != 0, 1);
        if (xq.size() != 0) begin
          xfer_t e;
          e = xq.pop_front();
          check("xfer_channel", cur_ch, e.ch);
          check("xfer_word", shreg, e.word);
          check("xfer_bits", nbits, DW);
        end
        nbits = 0;
      end
      if (!LD_n) ld_cnt++;
      if (LD_n && !prev_ld) begin
        check("ld_expected", ldq.size() != 0, 1);
        if (ldq.size() != 0) check("ld_width", ld_cnt, ldq.pop_front());
        ld_cnt = 0;
      end
      if (!CLR_n && prev_clr) clr_fall_cyc = cyc;
      if (!CLR_n) clr_cnt++;
      if (CLR_n && !prev_clr) begin
        check("clr_expected", clrq.size() != 0, 1);
        if (clrq.size() != 0) begin
          int f;
          f = clrq.pop_front();
          check("clr_width", clr_cnt, LDC);
          if (f >= 0) check("clr_fall_cycle", clr_fall_cyc, f);
        end
        clr_cnt = 0;
        clr_rise_cyc = cyc;
      end
      if (done) begin
        check("done_expected", doneq.size() != 0, 1);
        if (doneq.size() != 0) check("done_cycle", cyc, doneq.pop_front());
        last_done_cyc = cyc;
      end
      prev_cs = CS_n; prev_sclk = SCLK; prev_ld = LD_n; prev_clr = CLR_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    check("ready_timeout", ready, 1);
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (xq.size() + doneq.size() + ldq.size() + clrq.size() == 0) return;
    end
    check("drain_timeout", xq.size() + doneq.size() + ldq.size() + clrq.size(), 0);
  endtask

  // Reference model: enabled channels in ascending order, then LD strobe, then done.
  task automatic start_frame(input logic [DWALL-1:0] d, input logic [NC-1:0] m, output int acc);
    int n;
    wait_ready(400);
    ch_data = d; ch_mask = m; start = 1'b1;
    acc = cyc + 1;
    n = 0;
    for (int i = 0; i < NC; i++) if (m[i]) begin
      xfer_t x;
      x.ch = i; x.word = d[i*DW +: DW];
      xq.push_back(x);
      n++;
    end
    doneq.push_back(acc + ((n == 0) ? 1 : n * FRAME + LDC));
    if (n != 0) ldq.push_back(LDC);
    @(negedge clk);
    start = 1'b0;
    ch_data = DWALL'($urandom);
    ch_mask = NC'($urandom);
  endtask

  initial begin
    int acc;
    rst = 1'b1; locked = 1'b1; start = 1'b0; clr_req = 1'b0; ch_data = '0; ch_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", CS_n, 2'b11);
    check("rst_sclk", SCLK, 1);
    check("rst_sdi", SDI, 0);
    check("rst_ld_n", LD_n, 1);
    check("rst_clr_n", CLR_n, 1);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready, 1);

    // Known words on both channels
    start_frame({12'h123, 12'hAD5}, 2'b11, acc);
    wait_drain(400);
    // Only channel 1 enabled
    start_frame(DWALL'($urandom), 2'b10, acc);
    wait_drain(400);
    // Empty mask
    start_frame(DWALL'($urandom), 2'b00, acc);
    wait_drain(50);

    // Clear requested mid-frame is deferred until after done
    start_frame(DWALL'($urandom), 2'b11, acc);
    while (cyc < acc + 19) @(negedge clk);
    clr_req = 1'b1;
    clrq.push_back(-1);
    @(negedge clk);
    clr_req = 1'b0;
    wait_ready(400);
    check("ready_held_until_clr_done", (cyc >= clr_rise_cyc) && (clr_rise_cyc > last_done_cyc), 1);
    check("clr_after_done", clr_fall_cyc > last_done_cyc, 1);
    wait_drain(50);

    // Locked low in idle: start ignored, clear held pending
    locked = 1'b0;
    start = 1'b1; ch_mask = 2'b11;
    @(negedge clk);
    check("ready_locked_low", ready, 0);
    start = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (20) @(negedge clk);
    locked = 1'b1;
    clrq.push_back(cyc + 1);
    wait_drain(50);

    // Start and clear together: only the clear runs
    wait_ready(50);
    start = 1'b1; clr_req = 1'b1; ch_mask = 2'b11;
    clrq.push_back(cyc + 1);
    #1 check("ready_low_with_clr_req", ready, 0);
    @(negedge clk);
    start = 1'b0; clr_req = 1'b0;
    wait_drain(50);
    repeat (10) @(negedge clk);

    // Lock lost mid-frame: frame completes, clear stays pending until relock
    start_frame(DWALL'($urandom), 2'b11, acc);
    repeat (30) @(negedge clk);
    locked = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    wait_drain(400);
    repeat (10) @(negedge clk);
    check("ready_low_while_unlocked", ready, 0);
    locked = 1'b1;
    clrq.push_back(cyc + 1);
    wait_drain(50);

    // Random back-to-back frames
    for (int k = 0; k < 8; k++) start_frame(DWALL'($urandom), NC'($urandom), acc);
    wait_drain(1000);

    // Reset mid-frame aborts everything
    start_frame(DWALL'($urandom), 2'b11, acc);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cs_n", CS_n, 2'b11);
    check("midrst_sclk", SCLK, 1);
    check("midrst_sdi", SDI, 0);
    check("midrst_ld_n", LD_n, 1);
    check("midrst_clr_n", CLR_n, 1);
    check("midrst_done", done, 0);
    xq.delete(); doneq.delete(); ldq.delete(); clrq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", ready, 1);
    repeat (20) @(negedge clk);
    start_frame(DWALL'($urandom), 2'b01, acc);
    wait_drain(400);
    repeat (5) @(negedge clk);

    check("sdi_high_while_deselected", sdi_bad, 0);
    check("sclk_edges_while_deselected", stray, 0);
    check("multiple_cs_low", multi_cs, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dac_serial_multi.md
DAC_SERIAL_MULTI -- requirements
Module: dac_serial_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 12: bits per DAC word.
REQ-002 SHALL have parameter NUM_CH, default 2: number of serial DAC channels (1..8).
REQ-003 SHALL have parameter CLK_DIV, default 4: clk_50M cycles per SCLK half-period (>=1).
REQ-004 SHALL have parameter LD_CYCLES, default 3: width of the LD and CLR low pulses in clk_50M cycles (>=1).
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk_50M  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the remaining ports:
- locked  in  1  PLL lock; low holds the block idle.
- start  in  1  frame request; accepted when start & ready.
- ready  out  1  high when a start is accepted this cycle.
- ch_data  in  NUM_CH*DATA_W  channel words; ch i in bits [i*DATA_W +: DATA_W].
- ch_mask  in  NUM_CH  channel enables, latched with start.
- clr_req  in  1  one-cycle request for a DAC clear pulse.
- done  out  1  one-cycle pulse at frame end.
- CS_n  out  NUM_CH  per-channel chip select, active low.
- SCLK  out  1  shared serial clock; idles high.
- SDI  out  1  shared serial data, MSB first.
- LD_n  out  1  shared load strobe, active low.
- CLR_n  out  1  shared clear, active low.

Function
REQ-007 SHALL drive all serial outputs (CS_n, SCLK, SDI, LD_n, CLR_n, done) from registers.
REQ-008 SHALL define ready = (state==IDLE) & locked & ~clr_pend & ~clr_req, combinationally.
REQ-009 SHALL, on start & ready, latch ch_data and ch_mask; later changes to either SHALL NOT affect the frame in progress.
REQ-010 SHALL ignore start whenever ready is low, with no queuing.
REQ-011 SHALL implement the states IDLE, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, LD_PULSE, CLR_PULSE and DONE.
REQ-012 SHALL serve enabled channels in ascending index order and skip disabled channels with no bus activity.
REQ-013 SHALL run CS_SETUP as follows: the selected CS_n bit goes low with SCLK high, held for CLK_DIV cycles.
REQ-014 SHALL shift each bit as follows:
- SHIFT_LO: SCLK low and SDI updated to the next bit (MSB first), for CLK_DIV cycles.
- SHIFT_HI: SCLK high for CLK_DIV cycles; the DAC samples on the rising edge.
- Repeat for DATA_W bits.
REQ-015 SHALL, after the last SHIFT_HI, raise CS_n in CS_HOLD and hold it for CLK_DIV cycles before the next enabled channel.
REQ-016 SHALL take CLK_DIV*(2*DATA_W+2) cycles per enabled channel.
REQ-017 SHALL, after the last enabled channel, hold LD_n low for LD_CYCLES cycles (LD_PULSE), then enter DONE.
REQ-018 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-019 SHALL make the accept-to-done latency N*CLK_DIV*(2*DATA_W+2)+LD_CYCLES cycles, where N is the number of enabled channels.
REQ-020 SHALL, when ch_mask==0 at accept, assert done on the next cycle with no CS_n, SCLK or LD_n activity.
REQ-021 SHALL handle clear requests as follows:
- clr_req in IDLE: enter CLR_PULSE, CLR_n low for LD_CYCLES cycles, then IDLE.
- clr_req during a frame: set clr_pend; CLR_PULSE runs after DONE, before any new start.
- Repeated clr_req while pending: merged into one pulse.
REQ-022 SHALL give clr_req priority over start when both are asserted in IDLE in the same cycle; start is not accepted.
REQ-023 SHALL, when locked goes low mid-frame, finish the current frame; no new frame or clear SHALL start while locked is low, and a pending clear SHALL be retained.
REQ-024 SHALL keep SDI at 0 whenever no CS_n bit is low.

Reset
REQ-025 SHALL, while rst is high, immediately force: CS_n all 1, SCLK=1, SDI=0, LD_n=1, CLR_n=1, done=0, state=IDLE, clr_pend=0, latched data/mask=0.
REQ-026 SHALL abort any frame or pulse in progress on reset, with no LD_n pulse issued.

Verification (DATA_W=12, NUM_CH=2, CLK_DIV=2, LD_CYCLES=3)
REQ-027 Scenario: rst high mid-run -> outputs match REQ-025 in the same cycle; ready=1 after release with locked=1.
REQ-028 Scenario: ch_data={12'h123,12'hAD5}, mask=2'b11, start -> CS_n[0] low, SDI on 12 SCLK rising edges = 1010_1101_0101; then CS_n[1] low, SDI = 0001_0010_0011; LD_n low 3 cycles; done exactly 107 cycles after accept.
REQ-029 Scenario: mask=2'b10 -> CS_n[0] stays 1, only channel 1 shifted; done 55 cycles after accept.
REQ-030 Scenario: mask=2'b00 -> done on the next cycle; no SCLK edges.
REQ-031 Scenario: clr_req at cycle 20 of a frame -> frame completes unchanged; after done, CLR_n low 3 cycles; ready stays low until CLR_n returns high.
REQ-032 Scenario: locked=0 with start pulsed -> ready=0, no activity; start and clr_req in the same IDLE cycle -> only the CLR_n pulse occurs.
